// File: rtl/string_byte_streamer.sv
// ---------------------------------------------------------------------------
// string_byte_streamer
//
// Purpose:
//   Streams a packed string vector out one character per valid/ready
//   transfer. The first character is taken from the most significant
//   occupied byte.
//
//   The string and its effective length are captured when the stream starts.
//   The source may therefore change while the stream is still being sent.
//
// Ports:
//   c           clock; all state updates on its rising edge
//   rst_n       asynchronous active-low reset
//   str         packed string; n chars occupy [8*n-1:0], first at [8*n-1 -: 8]
//   len         number of characters to send (clamped to MAX_CHARS)
//   start       begin streaming; only honoured while idle
//   byte_data   current character (0 when not valid)
//   byte_valid  byte_data holds a character to transfer
//   byte_ready  consumer accepts byte_data when high with byte_valid
//   busy        high while characters are being sent
//   done        one-cycle pulse after the last transfer (or an empty string)
// ---------------------------------------------------------------------------
module string_byte_streamer #(
  parameter  int MAX_CHARS = 16,
  localparam int LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input  logic                   c,
  input  logic                   rst_n,
  input  logic [8*MAX_CHARS-1:0] str,
  input  logic [LEN_W-1:0]       len,
  input  logic                   start,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;        // bytes still to transfer
  logic [8*MAX_CHARS-1:0] shadow_q, shadow_d;  // captured string

  logic [LEN_W-1:0]       len_eff;
  logic [LEN_W-1:0]       cur_idx;

  // A length beyond the vector capacity sends the whole vector.
  assign len_eff = (len > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : len;

  // The remaining-byte count doubles as a pointer.
  // With cnt bytes left, the current character is byte (cnt-1) counted from the LSB.
  assign cur_idx = cnt_q - LEN_W'(1);

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = str;
          cnt_d    = len_eff;
          state_d  = (len_eff == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (byte_ready) begin
          // cnt is always >= 1 in SEND, so this decrement cannot wrap.
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The outputs decode the asynchronously reset state directly.
  // As a result, they fall as soon as rst_n asserts, without waiting for a clock edge.
  assign byte_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign done       = (state_q == DONE);
  assign byte_data  = (state_q == SEND) ? shadow_q[{cur_idx, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_string_byte_streamer.sv
// ---------------------------------------------------------------------------
// tb_string_byte_streamer
//
// Purpose:
//   Self-checking bench for string_byte_streamer with MAX_CHARS=16.
//
//   For every stream, a reference model builds the expected character
//   sequence from the captured string and its clamped length. The outputs
//   are then compared against that model cycle by cycle.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_string_byte_streamer;

  localparam int MAXC = 16;

  logic         c = 1'b0;
  logic         rst_n;
  logic [127:0] str;
  logic [4:0]   len;
  logic         start;
  logic [7:0]   byte_data;
  logic         byte_valid;
  logic         byte_ready;
  logic         busy;
  logic         done;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  string_byte_streamer #(.MAX_CHARS(MAXC)) dut (
    .c          (c),
    .rst_n      (rst_n),
    .str        (str),
    .len        (len),
    .start      (start),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 c = ~c;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Runs one stream from a start pulse to the idle cycle after done.
  //   hold:    number of initial valid cycles with byte_ready forced low
  //   rdy_pct: probability that byte_ready is high on later cycles
  //   poke:    keep changing str/len and holding start high during SEND and DONE
  task automatic run_stream(input logic [127:0] s, input logic [4:0] l,
                            input int rdy_pct, input int hold, input bit poke);
    logic [7:0]   exp_q[$];
    logic [127:0] tmp;
    int           lim;
    int           idx;
    int           cyc;
    lim = (int'(l) > MAXC) ? MAXC : int'(l);
    for (int k = 0; k < lim; k++) begin
      tmp = s >> (8 * (lim - 1 - k));
      exp_q.push_back(tmp[7:0]);
    end
    str   = s;
    len   = l;
    start = 1'b1;
    @(posedge c); #1;
    start = poke;
    idx = 0;
    cyc = 0;
    while (idx < lim) begin
      check_eq("valid", {31'd0, byte_valid}, 32'd1);
      check_eq("busy",  {31'd0, busy},       32'd1);
      check_eq("done_in_send", {31'd0, done}, 32'd0);
      check_eq("data",  {24'd0, byte_data},  {24'd0, exp_q[idx]});
      byte_ready = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
      if (poke) begin
        str = {$urandom, $urandom, $urandom, $urandom};
        len = 5'($urandom);
      end
      @(posedge c); #1;
      cyc++;
      if (byte_ready) idx++;
      if (cyc > 500) begin
        check_eq("timeout", 32'd1, 32'd0);
        break;
      end
    end
    // Done cycle: a single pulse with everything else quiet.
    check_eq("done_pulse", {31'd0, done},       32'd1);
    check_eq("valid_off",  {31'd0, byte_valid}, 32'd0);
    check_eq("busy_off",   {31'd0, busy},       32'd0);
    check_eq("data_zero",  {24'd0, byte_data},  32'd0);
    byte_ready = 1'($urandom);
    @(posedge c); #1;
    start = 1'b0;
    check_eq("done_once",  {31'd0, done},       32'd0);
    check_eq("idle_valid", {31'd0, byte_valid}, 32'd0);
    $display("stream len=%0d eff=%0d cycles=%0d hold=%0d rdy=%0d poke=%0d",
             l, lim, cyc, hold, rdy_pct, poke);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    str        = '0;
    len        = '0;
    byte_ready = 1'b0;
    #2;
    check_eq("rst_valid", {31'd0, byte_valid}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy},       32'd0);
    check_eq("rst_done",  {31'd0, done},       32'd0);
    check_eq("rst_data",  {24'd0, byte_data},  32'd0);
    @(posedge c); @(posedge c); #1;
    rst_n = 1'b1;
    @(posedge c); #1;

    // Basic "Hi".
    run_stream(128'h4869, 5'd2, 100, 0, 1'b0);
    // Backpressure on "abc".
    run_stream(128'h616263, 5'd3, 100, 3, 1'b0);
    // Empty string.
    run_stream(128'h4142, 5'd0, 100, 0, 1'b0);
    // Clamp: 20 requested, 16 sent.
    run_stream(128'h41424344_45464748_494a4b4c_4d4e4f50, 5'd20, 100, 0, 1'b0);
    // Snapshot: str/start poked during "Hi", then "XY".
    run_stream(128'h4869, 5'd2, 100, 0, 1'b1);
    run_stream(128'h5859, 5'd2, 100, 0, 1'b0);

    // Reset mid-stream on "abc" after the first byte has transferred.
    str = 128'h616263;
    len = 5'd3;
    start = 1'b1;
    byte_ready = 1'b1;
    @(posedge c); #1;
    start = 1'b0;
    check_eq("mid_first", {24'd0, byte_data}, 32'h61);
    @(posedge c); #1;
    check_eq("mid_second", {24'd0, byte_data}, 32'h62);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_valid", {31'd0, byte_valid}, 32'd0);
    check_eq("async_busy",  {31'd0, busy},       32'd0);
    check_eq("async_done",  {31'd0, done},       32'd0);
    check_eq("async_data",  {24'd0, byte_data},  32'd0);
    @(posedge c); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge c); #1;
      check_eq("post_rst_valid", {31'd0, byte_valid}, 32'd0);
      check_eq("post_rst_done",  {31'd0, done},       32'd0);
    end
    $display("reset mid-stream handled");

    // Randomized streams.
    for (int t = 0; t < 40; t++) begin
      run_stream({$urandom, $urandom, $urandom, $urandom}, 5'($urandom),
                 int'($urandom_range(20, 100)), int'($urandom_range(0, 3)),
                 1'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
